// File: rtl/clksel_if.sv
// Host-side handshake bundle for the PHI2 clock-selection stage: access hint, config bus,
// switch feedback and the registered select outputs.
interface clksel_if;
    logic       fast_req;
    logic       cfg_we;
    logic       cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       sw_busy;
    logic       sw_err;

    modport master (
        output fast_req, cfg_we, cfg_addr, cfg_wdata, hsclk_selected, lsclk_selected,
        input  cfg_rdata, hsclk_sel, cpuclk_div_sel, sw_busy, sw_err
    );

    modport slave (
        input  fast_req, cfg_we, cfg_addr, cfg_wdata, hsclk_selected, lsclk_selected,
        output cfg_rdata, hsclk_sel, cpuclk_div_sel, sw_busy, sw_err
    );
endinterface

// File: rtl/clksel_ctrl.sv
// Clock-selection policy FSM driving the PHI2 clock switch, with turbo/divider config register.
// Optional SWITCH_COUNT_EN adds an 8-bit HS-entry counter readable at status address.
module clksel_ctrl #(
    parameter int STARTUP_HOLDOFF = 16,
    parameter int MIN_HS_DWELL    = 2,
    parameter int SWITCH_TIMEOUT  = 15
) (
    input  logic     lsclk_in,
    input  logic     rst_b,
    clksel_if.slave  bus
);

    typedef enum logic [1:0] {ST_LS, ST_HS_REQ, ST_HS, ST_LS_REQ} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(STARTUP_HOLDOFF);
    localparam logic [3:0] DWELL_MAX = 4'(MIN_HS_DWELL);
    localparam logic [7:0] TMO_MAX   = 8'(SWITCH_TIMEOUT);

    state_t     state_q;
    logic [7:0] hold_q;
    logic [3:0] dwell_q;
    logic [7:0] tmo_q;
    logic       turbo_q;
    logic [1:0] divp_q;
    logic [1:0] div_q;
    logic       hs_sel_q;
    logic       busy_q;
    logic       err_q;
    logic       hs_meta_q;
    logic       hs_sync_q;
`ifdef SWITCH_COUNT_EN
    logic [7:0] cnt_q;
`endif

    logic holdoff_done, dwell_done, tmo_fire, ls_done, go_hs, hs_entry, err_set;
    logic wr_ctrl, wr_stat, err_clr;

    assign holdoff_done = (hold_q == 8'd0);
    assign dwell_done   = (dwell_q == DWELL_MAX);
    // Counter saturates at the limit so a stuck LS_REQ fires only once.
    assign tmo_fire     = (tmo_q != TMO_MAX) && ((tmo_q + 8'd1) == TMO_MAX);
    assign ls_done      = bus.lsclk_selected && !hs_sync_q;
    // Divider must already match the pending value, so it settles before HS is requested.
    assign go_hs        = turbo_q && bus.fast_req && holdoff_done && bus.lsclk_selected &&
                          (div_q == divp_q);
    assign hs_entry     = (state_q == ST_HS_REQ) && hs_sync_q;
    assign err_set      = tmo_fire && (((state_q == ST_HS_REQ) && !hs_sync_q) ||
                                       ((state_q == ST_LS_REQ) && !ls_done));
    assign wr_ctrl      = bus.cfg_we && !bus.cfg_addr;
    assign wr_stat      = bus.cfg_we &&  bus.cfg_addr;
    assign err_clr      = wr_stat && bus.cfg_wdata[2];

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_LS;
            hold_q    <= HOLD_INIT;
            dwell_q   <= 4'd0;
            tmo_q     <= 8'd0;
            turbo_q   <= 1'b0;
            divp_q    <= 2'b10;
            div_q     <= 2'b10;
            hs_sel_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            hs_meta_q <= 1'b0;
            hs_sync_q <= 1'b0;
`ifdef SWITCH_COUNT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            hs_meta_q <= bus.hsclk_selected;
            hs_sync_q <= hs_meta_q;
            if (!holdoff_done) hold_q <= hold_q - 8'd1;

            if (wr_ctrl) begin
                turbo_q <= bus.cfg_wdata[0];
                divp_q  <= bus.cfg_wdata[2:1];
            end

            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;

`ifdef SWITCH_COUNT_EN
            if (wr_stat && bus.cfg_wdata[7]) cnt_q <= 8'd0;
            else if (hs_entry)               cnt_q <= cnt_q + 8'd1;
`endif

            case (state_q)
                ST_LS: begin
                    div_q <= divp_q;
                    if (go_hs) begin
                        state_q  <= ST_HS_REQ;
                        hs_sel_q <= 1'b1;
                        busy_q   <= 1'b1;
                        tmo_q    <= 8'd0;
                    end
                end
                ST_HS_REQ: begin
                    if (hs_entry) begin
                        state_q <= ST_HS;
                        busy_q  <= 1'b0;
                        dwell_q <= 4'd0;
                    end else if (tmo_fire) begin
                        state_q  <= ST_LS_REQ;
                        hs_sel_q <= 1'b0;
                        tmo_q    <= 8'd0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                ST_HS: begin
                    if (!dwell_done) dwell_q <= dwell_q + 4'd1;
                    // Turbo-off bypasses the dwell requirement.
                    if ((!bus.fast_req && dwell_done) || !turbo_q) begin
                        state_q  <= ST_LS_REQ;
                        hs_sel_q <= 1'b0;
                        busy_q   <= 1'b1;
                        tmo_q    <= 8'd0;
                    end
                end
                ST_LS_REQ: begin
                    if (ls_done) begin
                        state_q <= ST_LS;
                        busy_q  <= 1'b0;
                    end else if (tmo_q != TMO_MAX) begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= ST_LS;
            endcase
        end
    end

    assign bus.hsclk_sel      = hs_sel_q;
    assign bus.cpuclk_div_sel = div_q;
    assign bus.sw_busy        = busy_q;
    assign bus.sw_err         = err_q;

    always_comb begin
        bus.cfg_rdata = 8'h00;
        if (!bus.cfg_addr) begin
            bus.cfg_rdata = {5'b0, divp_q, turbo_q};
        end else begin
`ifdef SWITCH_COUNT_EN
            bus.cfg_rdata = cnt_q;
`else
            bus.cfg_rdata = {4'h0, holdoff_done, err_q, busy_q, hs_sel_q};
`endif
        end
    end

endmodule

// File: tb/tb_clksel_ctrl.sv
// Randomized bench for clksel_ctrl against a cycle-level behavioural model (mode + age counters).
module tb_clksel_ctrl;
    localparam int H = 16, DW = 2, TO = 15;
    localparam int M_LS = 0, M_HSR = 1, M_HS = 2, M_LSR = 3;

    logic lsclk_in = 1'b0;
    logic rst_b    = 1'b0;
    clksel_if bus();

    clksel_ctrl #(.STARTUP_HOLDOFF(H), .MIN_HS_DWELL(DW), .SWITCH_TIMEOUT(TO)) dut (
        .lsclk_in (lsclk_in),
        .rst_b    (rst_b),
        .bus      (bus)
    );

    always #5 lsclk_in = ~lsclk_in;

    int checks = 0, errors = 0;
    int m_mode, m_age, m_cyc;
    bit m_turbo, m_err, m_hsm, m_hss;
    bit [1:0] m_divp, m_div;
    bit [7:0] m_cnt;
    bit emu_on = 0, stuck = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_LS; m_age = 0; m_cyc = 0;
        m_turbo = 0; m_err = 0; m_hsm = 0; m_hss = 0;
        m_divp = 2'b10; m_div = 2'b10; m_cnt = 8'd0;
    endtask

    // One rising edge worth of spec behaviour, using the inputs held before the edge.
    task automatic model_step();
        int nm;
        bit eset, eclr;
        nm = m_mode; eset = 0; eclr = 0;
        case (m_mode)
            M_LS: begin
                if (m_turbo && bus.fast_req && m_cyc >= H && bus.lsclk_selected && m_div == m_divp)
                    nm = M_HSR;
                m_div = m_divp;
            end
            M_HSR: begin
                if (m_hss) begin nm = M_HS; m_cnt = m_cnt + 8'd1; end
                else if (m_age == TO - 1) begin eset = 1; nm = M_LSR; end
            end
            M_HS:  if ((!bus.fast_req && m_age >= DW) || !m_turbo) nm = M_LSR;
            default: begin
                if (bus.lsclk_selected && !m_hss) nm = M_LS;
                else if (m_age == TO - 1) eset = 1;
            end
        endcase
        m_age  = (nm != m_mode) ? 0 : m_age + 1;
        m_mode = nm;
        if (m_cyc < H) m_cyc++;
        if (bus.cfg_we) begin
            if (!bus.cfg_addr) begin
                m_turbo = bus.cfg_wdata[0];
                m_divp  = bus.cfg_wdata[2:1];
            end else begin
                eclr = bus.cfg_wdata[2];
                if (bus.cfg_wdata[7]) m_cnt = 8'd0;
            end
        end
        m_err = eset ? 1'b1 : (eclr ? 1'b0 : m_err);
        m_hss = m_hsm;
        m_hsm = bus.hsclk_selected;
    endtask

    function automatic logic [7:0] model_rdata();
        if (!bus.cfg_addr) return {5'b0, m_divp, m_turbo};
`ifdef SWITCH_COUNT_EN
        return m_cnt;
`else
        return {4'h0, (m_cyc >= H), m_err, (m_mode == M_HSR || m_mode == M_LSR),
                (m_mode == M_HSR || m_mode == M_HS)};
`endif
    endfunction

    task automatic compare();
        chk("hsclk_sel", {7'b0, bus.hsclk_sel}, {7'b0, (m_mode == M_HSR || m_mode == M_HS)});
        chk("sw_busy",   {7'b0, bus.sw_busy},   {7'b0, (m_mode == M_HSR || m_mode == M_LSR)});
        chk("sw_err",    {7'b0, bus.sw_err},    {7'b0, m_err});
        chk("div_sel",   {6'b0, bus.cpuclk_div_sel}, {6'b0, m_div});
        chk("cfg_rdata", bus.cfg_rdata, model_rdata());
    endtask

    // Crude clock switch: follows the request with a random lag unless stuck.
    task automatic emu();
        if (!stuck && $urandom_range(3) != 0) begin
            bus.hsclk_selected = bus.hsclk_sel;
            bus.lsclk_selected = !bus.hsclk_sel;
        end
    endtask

    task automatic tick();
        @(posedge lsclk_in);
        if (rst_b) model_step();
        #1;
        compare();
        if (emu_on) emu();
    endtask

    task automatic wr(input bit a, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_busy_low(input string name);
        int n;
        n = 0;
        while (bus.sw_busy && n < 12) begin tick(); n++; end
        chk(name, {7'b0, bus.sw_busy}, 8'h00);
    endtask

    task automatic do_reset_mid();
        #2 rst_b = 1'b0;
        #1;
        model_reset();
        chk("areset_hs",   {7'b0, bus.hsclk_sel}, 8'h00);
        chk("areset_busy", {7'b0, bus.sw_busy},   8'h00);
        chk("areset_div",  {6'b0, bus.cpuclk_div_sel}, 8'h02);
        tick(); tick();
        rst_b = 1'b1;
    endtask

`ifdef SWITCH_COUNT_EN
    task automatic hs_round();
        int n;
        bus.fast_req = 1'b1;
        n = 0;
        while (!(bus.hsclk_sel && !bus.sw_busy) && n < 40) begin tick(); n++; end
        if (n >= 40) chk("round_hs_timeout", 8'h01, 8'h00);
        bus.fast_req = 1'b0;
        n = 0;
        while ((bus.hsclk_sel || bus.sw_busy) && n < 40) begin tick(); n++; end
        if (n >= 40) chk("round_ls_timeout", 8'h01, 8'h00);
    endtask
`endif

    initial begin
        bus.fast_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 1'b0; bus.cfg_wdata = 8'h00;
        bus.hsclk_selected = 1'b0; bus.lsclk_selected = 1'b1;
        model_reset();
        #12;
        chk("rst_hs",    {7'b0, bus.hsclk_sel}, 8'h00);
        chk("rst_div",   {6'b0, bus.cpuclk_div_sel}, 8'h02);
        chk("rst_busy",  {7'b0, bus.sw_busy}, 8'h00);
        chk("rst_err",   {7'b0, bus.sw_err}, 8'h00);
        chk("rst_ctrl",  bus.cfg_rdata, 8'h04);
        compare();
        rst_b = 1'b1;

        // Holdoff: request cannot rise before edge 17.
        wr(1'b0, 8'h05);
        repeat (15) tick();
        chk("holdoff_lo", {7'b0, bus.hsclk_sel}, 8'h00);
        tick();
        chk("holdoff_rise", {7'b0, bus.hsclk_sel}, 8'h01);
        chk("hsreq_busy",   {7'b0, bus.sw_busy},   8'h01);

        // Synchronized handshake into HS.
        bus.hsclk_selected = 1'b1; bus.lsclk_selected = 1'b0;
        tick(); tick();
        chk("sync_wait", {7'b0, bus.sw_busy}, 8'h01);
        tick();
        chk("hs_enter", {7'b0, bus.sw_busy}, 8'h00);

        // Divider write in HS is deferred; dwell holds HS after fast_req drops.
        wr(1'b0, 8'h01);
        bus.fast_req = 1'b0;
        tick();
        chk("dwell_hold", {7'b0, bus.hsclk_sel}, 8'h01);
        tick();
        chk("dwell_exit", {7'b0, bus.hsclk_sel}, 8'h00);
        chk("div_held",   {6'b0, bus.cpuclk_div_sel}, 8'h02);
        bus.hsclk_selected = 1'b0; bus.lsclk_selected = 1'b1;
        wait_busy_low("ls_return");
        tick();
        chk("div_applied", {6'b0, bus.cpuclk_div_sel}, 8'h00);

        // Divider settles before the HS request rises.
        wr(1'b0, 8'h03);
        chk("div_pre", {7'b0, bus.hsclk_sel}, 8'h00);
        bus.fast_req = 1'b1;
        tick();
        chk("div_first", {6'b0, bus.cpuclk_div_sel}, 8'h01);
        chk("hs_after_div", {7'b0, bus.hsclk_sel}, 8'h00);
        tick();
        chk("req_rise", {7'b0, bus.hsclk_sel}, 8'h01);

        // Handshake timeout.
        repeat (14) tick();
        chk("tmo_pre", {7'b0, bus.sw_err}, 8'h00);
        tick();
        chk("tmo_err", {7'b0, bus.sw_err}, 8'h01);
        chk("tmo_hs",  {7'b0, bus.hsclk_sel}, 8'h00);
        wr(1'b1, 8'h04);
        chk("err_clr", {7'b0, bus.sw_err}, 8'h00);

        // Async reset during a fresh request.
        tick();
        chk("req_again", {7'b0, bus.hsclk_sel}, 8'h01);
        do_reset_mid();

        // Randomized traffic against the model.
        emu_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) bus.fast_req = ~bus.fast_req;
            if ($urandom_range(79) == 0) stuck = ~stuck;
            bus.cfg_addr = 1'($urandom_range(1));
            bus.cfg_we = ($urandom_range(11) == 0);
            bus.cfg_wdata = 8'($urandom);
            if (!bus.cfg_addr) bus.cfg_wdata[0] = ($urandom_range(3) != 0);
            if (i == 1500) do_reset_mid();
            else tick();
        end
        bus.cfg_we = 1'b0;

`ifdef SWITCH_COUNT_EN
        stuck = 1'b0;
        bus.fast_req = 1'b0;
        wr(1'b0, 8'h05);
        repeat (20) tick();
        wr(1'b1, 8'h84);
        bus.cfg_addr = 1'b1;
        for (int r = 0; r < 256; r++) hs_round();
        chk("cnt_wrap", bus.cfg_rdata, 8'h00);
        for (int r = 0; r < 3; r++) hs_round();
        chk("cnt_three", bus.cfg_rdata, 8'h03);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
